// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: FSM state encodings
// and the instruction address width.
package pipe_ctrl_pkg;

    // Width of instruction addresses and redirect targets.
    localparam int unsigned AddrWidth = 32;

    // Pipeline control FSM states.
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StWaitBus = 2'd1,
        StFlush   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/hold_watchdog.sv
// Execute-hold watchdog: a saturating count of consecutive hold cycles and a
// sticky flag that sets once the count reaches HOLD_TIMEOUT. HOLD_TIMEOUT=0
// disables the flag entirely.
module hold_watchdog #(
    parameter int unsigned HOLD_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_inc_i,
    output logic hold_timeout_o
);

    localparam int unsigned CntW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(HOLD_TIMEOUT);

    logic [CntW-1:0] cnt_d, cnt_q;
    logic            flag_d, flag_q;

    // Next count (saturating, cleared on any non-hold cycle) and sticky flag.
    always_comb begin
        cnt_d  = '0;
        flag_d = flag_q;
        if (hold_inc_i) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        end
        if ((HOLD_TIMEOUT != 0) && (cnt_d == CntMax)) begin
            flag_d = 1'b1;
        end
    end

    // Counter and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign hold_timeout_o = flag_q & ~rst;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: turns execute redirects/holds and instruction-bus
// holds into per-stage stall/flush controls and a sequenced pc redirect.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_CNT_EN.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned HOLD_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jump_en_i,
    input  logic [AddrWidth-1:0] jump_addr_i,
    input  logic                 hold_flag_i,
    input  logic                 bus_hold_i,
    output logic                 jump_en_o,
    output logic [AddrWidth-1:0] jump_addr_o,
    output logic                 stall_pc_o,
    output logic                 stall_if_id_o,
    output logic                 stall_id_ex_o,
    output logic                 flush_if_id_o,
    output logic                 flush_id_ex_o,
    output logic                 busy_o,
`ifdef PIPE_CTRL_PERF_CNT_EN
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          flush_cnt_o,
`endif
    output logic                 hold_timeout_o
);

    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES);

    pipe_state_e          state_d, state_q;
    logic [2:0]           fcnt_d, fcnt_q;
    logic [AddrWidth-1:0] pend_d, pend_q;

    logic                 jump_en, stall_pc, stall_if_id, stall_id_ex;
    logic                 flush_if_id, flush_id_ex;
    logic [AddrWidth-1:0] jump_addr;

    // Next-state and raw control decode; redirects go through FLUSH unless
    // the fetch latency is zero.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pend_d      = pend_q;
        jump_en     = 1'b0;
        jump_addr   = '0;
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        stall_id_ex = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        case (state_q)
            StRun: begin
                if (jump_en_i && !bus_hold_i) begin
                    jump_en     = 1'b1;
                    jump_addr   = jump_addr_i;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (FLUSH_CYCLES != 0) begin
                        state_d = StFlush;
                        fcnt_d  = FlushInit;
                    end
                end else if (jump_en_i) begin
                    pend_d      = jump_addr_i;
                    stall_pc    = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    state_d     = StWaitBus;
                end else if (hold_flag_i) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    stall_id_ex = 1'b1;
                end else if (bus_hold_i) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            StWaitBus: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (bus_hold_i) begin
                    stall_pc = 1'b1;
                end else begin
                    jump_en   = 1'b1;
                    jump_addr = pend_q;
                    if (FLUSH_CYCLES != 0) begin
                        state_d = StFlush;
                        fcnt_d  = FlushInit;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StFlush: begin
                flush_if_id = 1'b1;
                if (bus_hold_i) begin
                    stall_pc = 1'b1;
                end else if (fcnt_q <= 3'd1) begin
                    fcnt_d  = '0;
                    state_d = StRun;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State, flush counter and deferred redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            fcnt_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
        end
    end

    // Outputs are forced low in reset; a flush overrides a stall on the same register.
    assign jump_en_o     = jump_en & ~rst;
    assign jump_addr_o   = rst ? '0 : jump_addr;
    assign stall_pc_o    = stall_pc & ~rst;
    assign stall_if_id_o = stall_if_id & ~flush_if_id & ~rst;
    assign stall_id_ex_o = stall_id_ex & ~flush_id_ex & ~rst;
    assign flush_if_id_o = flush_if_id & ~rst;
    assign flush_id_ex_o = flush_id_ex & ~rst;
    assign busy_o        = (state_q != StRun) & ~rst;

    hold_watchdog #(
        .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) u_hold_watchdog (
        .clk           (clk),
        .rst           (rst),
        .hold_inc_i    (~rst & (state_q == StRun) & hold_flag_i & ~jump_en_i),
        .hold_timeout_o(hold_timeout_o)
    );

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(stall_pc_o);
            flush_cnt_q <= flush_cnt_q + 32'(jump_en_o);
        end
    end

    assign stall_cnt_o = rst ? '0 : stall_cnt_q;
    assign flush_cnt_o = rst ? '0 : flush_cnt_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned FLUSH_CYCLES = 1;
    localparam int unsigned HOLD_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        bus_hold_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        stall_pc_o, stall_if_id_o, stall_id_ex_o;
    logic        flush_if_id_o, flush_id_ex_o;
    logic        busy_o, hold_timeout_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    pipe_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .bus_hold_i    (bus_hold_i),
        .jump_en_o     (jump_en_o),
        .jump_addr_o   (jump_addr_o),
        .stall_pc_o    (stall_pc_o),
        .stall_if_id_o (stall_if_id_o),
        .stall_id_ex_o (stall_id_ex_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .busy_o        (busy_o),
`ifdef PIPE_CTRL_PERF_CNT_EN
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
`endif
        .hold_timeout_o(hold_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: a redirect waiting on the bus, the remaining
    // flush window, the current run of hold cycles and the sticky timeout.
    bit          m_pend;
    logic [31:0] m_paddr;
    int unsigned m_flush_left;
    int unsigned m_hold_run;
    bit          m_to;
    logic [31:0] m_scnt, m_fcnt;

    // Expected outputs for the current cycle.
    bit          e_jump, e_spc, e_sif, e_sid, e_fif, e_fid, e_busy, e_to;
    logic [31:0] e_addr, e_scnt, e_fcnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs for this cycle, then advance the model across the edge.
    task automatic model_cycle(input logic r, input logic je, input logic [31:0] ja,
                               input logic hf, input logic bh);
        bit in_run;
        e_jump = 0; e_spc = 0; e_sif = 0; e_sid = 0; e_fif = 0; e_fid = 0; e_busy = 0;
        e_addr = '0;
        e_to   = m_to && !r;
        e_scnt = r ? 32'd0 : m_scnt;
        e_fcnt = r ? 32'd0 : m_fcnt;
        if (r) begin
            m_pend = 0; m_paddr = '0; m_flush_left = 0; m_hold_run = 0; m_to = 0;
            m_scnt = '0; m_fcnt = '0;
            return;
        end
        in_run = !m_pend && (m_flush_left == 0);
        e_busy = !in_run;
        if (m_pend) begin
            e_fif = 1; e_fid = 1;
            if (bh) begin
                e_spc = 1;
            end else begin
                e_jump = 1; e_addr = m_paddr;
                m_pend = 0; m_flush_left = FLUSH_CYCLES;
            end
        end else if (m_flush_left > 0) begin
            e_fif = 1;
            if (bh) e_spc = 1;
            else    m_flush_left--;
        end else if (je && !bh) begin
            e_jump = 1; e_addr = ja; e_fif = 1; e_fid = 1;
            m_flush_left = FLUSH_CYCLES;
        end else if (je) begin
            e_spc = 1; e_fif = 1; e_fid = 1;
            m_pend = 1; m_paddr = ja;
        end else if (hf) begin
            e_spc = 1; e_sif = 1; e_sid = 1;
        end else if (bh) begin
            e_spc = 1; e_sif = 1; e_fid = 1;
        end
        if (e_fif) e_sif = 0;
        if (e_fid) e_sid = 0;
        if (in_run && hf && !je) begin
            if (m_hold_run < HOLD_TIMEOUT) m_hold_run++;
        end else begin
            m_hold_run = 0;
        end
        if ((HOLD_TIMEOUT != 0) && (m_hold_run == HOLD_TIMEOUT)) m_to = 1;
        m_scnt = m_scnt + 32'(e_spc);
        m_fcnt = m_fcnt + 32'(e_jump);
    endtask

    // Drive one cycle of inputs away from the active edge, compare, advance model.
    task automatic step(input logic r, input logic je, input logic [31:0] ja,
                        input logic hf, input logic bh);
        @(negedge clk);
        rst = r; jump_en_i = je; jump_addr_i = ja; hold_flag_i = hf; bus_hold_i = bh;
        #1;
        model_cycle(r, je, ja, hf, bh);
        check_eq("ctrl{jmp,spc,sif,sid,fif,fid,busy}",
                 32'({jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
                      flush_if_id_o, flush_id_ex_o, busy_o}),
                 32'({e_jump, e_spc, e_sif, e_sid, e_fif, e_fid, e_busy}));
        check_eq("jump_addr", jump_addr_o, e_addr);
        check_eq("hold_timeout", 32'(hold_timeout_o), 32'(e_to));
`ifdef PIPE_CTRL_PERF_CNT_EN
        check_eq("stall_cnt", stall_cnt_o, e_scnt);
        check_eq("flush_cnt", flush_cnt_o, e_fcnt);
`endif
    endtask

    initial begin
        logic        r, je, hf, bh;
        logic [31:0] ja;
        rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; hold_flag_i = 1'b0; bus_hold_i = 1'b0;
        m_pend = 0; m_paddr = '0; m_flush_left = 0; m_hold_run = 0; m_to = 0;
        m_scnt = '0; m_fcnt = '0;

        // Reset with a redirect request present: everything stays low.
        step(1, 1, 32'h100, 0, 0);
        check_eq("rst_jump_en", 32'(jump_en_o), 32'd0);
        step(1, 1, 32'h100, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        check_eq("idle_busy", 32'(busy_o), 32'd0);

        // Plain jump: zero-latency redirect, then one flush-window cycle.
        step(0, 1, 32'h40, 0, 0);
        check_eq("jump_addr_40", jump_addr_o, 32'h40);
        step(0, 0, 32'h0, 0, 0);
        check_eq("flush_window_busy", 32'({busy_o, flush_if_id_o, flush_id_ex_o}), 32'b110);
        step(0, 0, 32'h0, 0, 0);

        // Deferred jump: target captured on entry, later changes ignored.
        step(0, 1, 32'h80, 0, 1);
        step(0, 1, 32'h84, 0, 1);
        step(0, 1, 32'h88, 1, 1);
        check_eq("defer_wait", 32'({jump_en_o, stall_pc_o, flush_if_id_o, flush_id_ex_o}),
                 32'b0111);
        step(0, 0, 32'h0, 0, 0);
        check_eq("defer_addr", jump_addr_o, 32'h80);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);

        // Priority: execute hold beats bus hold; a jump beats both.
        step(0, 0, 32'h0, 1, 1);
        check_eq("prio_hold", 32'({stall_pc_o, stall_if_id_o, stall_id_ex_o,
                                   flush_if_id_o, flush_id_ex_o}), 32'b11100);
        step(0, 1, 32'h200, 1, 1);
        check_eq("prio_jump", 32'({stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o}),
                 32'b0011);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);

        // Watchdog: a 3-cycle hold then a gap must not trip it.
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 0);
        check_eq("wd_short", 32'(hold_timeout_o), 32'd0);
        // A 6-cycle hold trips it after the 4th cycle; it stays set until reset.
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 0);
        check_eq("wd_before", 32'(hold_timeout_o), 32'd0);
        step(0, 0, 32'h0, 1, 0);
        check_eq("wd_set", 32'(hold_timeout_o), 32'd1);
        step(0, 0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 0);
        check_eq("wd_sticky", 32'(hold_timeout_o), 32'd1);
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        check_eq("wd_cleared", 32'(hold_timeout_o), 32'd0);

        // Reset while a redirect waits on the bus discards it.
        step(0, 1, 32'h300, 0, 1);
        step(0, 0, 32'h0, 0, 1);
        step(1, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 0);
        check_eq("rst_mid_jump", 32'({jump_en_o, busy_o}), 32'd0);
`ifdef PIPE_CTRL_PERF_CNT_EN
        check_eq("rst_mid_cnts", stall_cnt_o | flush_cnt_o, 32'd0);
`endif

        // Random stimulus; execute hold is sticky so the watchdog gets exercised.
        hf = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            je = ($urandom_range(0, 7) == 0);
            bh = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) hf = ~hf;
            ja = $urandom;
            step(r, je, ja, hf, bh);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
